// File: rtl/io_pkg.sv
// Shared register map and decode helpers for the memory-mapped I/O controller.
package io_pkg;

  localparam int NUM_SW = 10;

  localparam logic [7:0] OFF_OUT0   = 8'h00;
  localparam logic [7:0] OFF_OUT1   = 8'h04;
  localparam logic [7:0] OFF_OUT2   = 8'h08;
  localparam logic [7:0] OFF_IN0    = 8'h80;
  localparam logic [7:0] OFF_IN1    = 8'h84;
  localparam logic [7:0] OFF_STATUS = 8'h88;

  function automatic logic is_wr_off(input logic [7:0] off);
    return (off == OFF_OUT0) || (off == OFF_OUT1) || (off == OFF_OUT2);
  endfunction

  function automatic logic is_rd_off(input logic [7:0] off);
    return is_wr_off(off) || (off == OFF_IN0) || (off == OFF_IN1) || (off == OFF_STATUS);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-switch debouncer: two-flop synchronizer followed by a stable/counting FSM.
// state       | meaning
// ST_STABLE   | debounced value matches synchronized input
// ST_COUNTING | input differs, counting toward acceptance
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  logic          r_sync1;
  logic          r_sync2;
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_change;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_state  <= ST_STABLE;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_change <= 1'b0;
      if (r_state == ST_STABLE) begin
        if (r_sync2 != r_stable) begin
          r_state <= ST_COUNTING;
          r_cnt   <= '0;
        end
      end else begin
        if (r_sync2 == r_stable) begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_change <= 1'b1;
          r_state  <= ST_STABLE;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_change = r_change;

endmodule

// File: rtl/io_port_controller.sv
// CPU-facing I/O window: three output port registers, two debounced switch
// input ports and a sticky read-clear change-status register.
module io_port_controller
  import io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  output logic        io_err,
  input  logic [9:0]  sw,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1
);

  logic              w_hit;
  logic [7:0]        w_off;
  logic              w_wr_ok;
  logic              w_wr_bad;
  logic              w_rd_hit;
  logic              w_rd_bad;
  logic              w_status_clr;
  logic [31:0]       w_rd_mux;
  logic [NUM_SW-1:0] w_stable;
  logic [NUM_SW-1:0] w_change;

  logic [31:0]       r_out0;
  logic [31:0]       r_out1;
  logic [31:0]       r_out2;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic [NUM_SW-1:0] r_status;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (sw[g]),
      .o_stable (w_stable[g]),
      .o_change (w_change[g])
    );
  end

  // Misaligned offsets never equal a mapped offset, so they fall into the error path.
  assign w_hit        = (io_addr[31:8] == IO_BASE[31:8]);
  assign w_off        = io_addr[7:0];
  assign w_wr_ok      = io_we & w_hit & is_wr_off(w_off);
  assign w_wr_bad     = io_we & w_hit & ~is_wr_off(w_off);
  assign w_rd_hit     = io_re & w_hit;
  assign w_rd_bad     = w_rd_hit & ~is_rd_off(w_off);
  assign w_status_clr = w_rd_hit & (w_off == OFF_STATUS);

  assign in_port0 = {27'b0, w_stable[4:0]};
  assign in_port1 = {27'b0, w_stable[9:5]};

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_OUT0:   w_rd_mux = r_out0;
      OFF_OUT1:   w_rd_mux = r_out1;
      OFF_OUT2:   w_rd_mux = r_out2;
      OFF_IN0:    w_rd_mux = in_port0;
      OFF_IN1:    w_rd_mux = in_port1;
      OFF_STATUS: w_rd_mux = {{(32-NUM_SW){1'b0}}, r_status};
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out0   <= '0;
      r_out1   <= '0;
      r_out2   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_status <= '0;
    end else begin
      if (w_wr_ok) begin
        case (w_off)
          OFF_OUT0: r_out0 <= io_wdata;
          OFF_OUT1: r_out1 <= io_wdata;
          OFF_OUT2: r_out2 <= io_wdata;
          default:  ;
        endcase
      end
      r_rvalid <= w_rd_hit;
      if (w_rd_hit) r_rdata <= w_rd_mux;
      r_err <= w_wr_bad | w_rd_bad;
      // A change arriving with the read-clear survives, so no event is lost.
      if (w_status_clr) r_status <= w_change;
      else              r_status <= r_status | w_change;
    end
  end

  assign out_port0 = r_out0;
  assign out_port1 = r_out1;
  assign out_port2 = r_out2;
  assign io_rdata  = r_rdata;
  assign io_rvalid = r_rvalid;
  assign io_err    = r_err;

endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench for io_port_controller with a short debounce window.
module tb_io_port_controller;

  localparam int          DEB  = 4;
  localparam int          LAT  = 2 + DEB + 1;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk;
  logic        reset;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        io_err;
  logic [9:0]  sw;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [31:0] in_port0;
  logic [31:0] in_port1;

  int ncmp  = 0;
  int nfail = 0;

  io_port_controller #(.DEBOUNCE_CYCLES(DEB), .IO_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_rdata  (io_rdata),
    .io_rvalid (io_rvalid),
    .io_err    (io_err),
    .sw        (sw),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .in_port0  (in_port0),
    .in_port1  (in_port1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    cyc();
    io_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v, output logic e);
    io_addr = a;
    io_re   = 1'b1;
    cyc();
    d       = io_rdata;
    v       = io_rvalid;
    e       = io_err;
    io_re   = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        v, e;
    sw = 10'h3FF;
    cyc(LAT + 3);
    wr(BASE | 32'h00, 32'hA5A5_0001);
    wr(BASE | 32'h04, 32'hA5A5_0002);
    wr(BASE | 32'h08, 32'hA5A5_0003);
    rd(BASE | 32'h84, d, v, e);
    ncmp++;
    if (d !== 32'h1F) begin nfail++; $display("FAIL pre_reset_in1: got %h want %h", d, 32'h1F); end
    #2 reset = 1'b1;
    #1;
    ncmp++;
    if ({out_port0, out_port1, out_port2, in_port0, in_port1, io_rdata} !== '0 || io_rvalid !== 1'b0 || io_err !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: out %h %h %h in %h %h rdata %h rv %b err %b want all 0",
               out_port0, out_port1, out_port2, in_port0, in_port1, io_rdata, io_rvalid, io_err);
    end
    cyc(2);
    reset = 1'b0;
    rd(BASE | 32'h80, d, v, e);
    ncmp++;
    if (d !== 32'h0 || v !== 1'b1 || e !== 1'b0) begin
      nfail++; $display("FAIL post_reset_read: rdata %h rv %b err %b want 0 1 0", d, v, e);
    end
    cyc();
    ncmp++;
    if (io_rvalid !== 1'b0) begin nfail++; $display("FAIL rvalid_pulse: got %b want 0", io_rvalid); end
    cyc(LAT - 3);
    ncmp++;
    if (in_port0 !== 32'h0) begin nfail++; $display("FAIL redebounce_early: got %h want 0", in_port0); end
    cyc();
    ncmp++;
    if (in_port0 !== 32'h1F || in_port1 !== 32'h1F) begin
      nfail++; $display("FAIL redebounce_done: got %h %h want 1f 1f", in_port0, in_port1);
    end
    sw = 10'h000;
    cyc(LAT + 4);
    rd(BASE | 32'h88, d, v, e);
  endtask

  task automatic test_write_readback;
    logic [31:0] d;
    logic        v, e;
    wr(BASE | 32'h04, 32'h0000_0012);
    ncmp++;
    if (out_port1 !== 32'h12) begin nfail++; $display("FAIL wr_out1: got %h want 12", out_port1); end
    rd(BASE | 32'h04, d, v, e);
    ncmp++;
    if (d !== 32'h12 || v !== 1'b1) begin nfail++; $display("FAIL rd_out1: got %h rv %b want 12 1", d, v); end
    io_addr  = BASE | 32'h04;
    io_wdata = 32'h55;
    io_we    = 1'b1;
    io_re    = 1'b1;
    cyc();
    io_we    = 1'b0;
    io_re    = 1'b0;
    ncmp++;
    if (io_rdata !== 32'h12 || out_port1 !== 32'h55) begin
      nfail++; $display("FAIL rw_same_cycle: rdata %h out1 %h want 12 55", io_rdata, out_port1);
    end
  endtask

  task automatic test_debounce_accept;
    logic [31:0] d;
    logic        v, e;
    sw[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      ncmp++;
      if (in_port0 !== ((k >= LAT) ? 32'h1 : 32'h0)) begin
        nfail++; $display("FAIL accept_cycle%0d: got %h want %h", k, in_port0, (k >= LAT) ? 32'h1 : 32'h0);
      end
    end
    cyc();
    rd(BASE | 32'h88, d, v, e);
    ncmp++;
    if (d !== 32'h001) begin nfail++; $display("FAIL status_first: got %h want 001", d); end
    rd(BASE | 32'h88, d, v, e);
    ncmp++;
    if (d !== 32'h000) begin nfail++; $display("FAIL status_cleared: got %h want 000", d); end
  endtask

  task automatic test_glitch_reject;
    logic [31:0] d;
    logic        v, e;
    int          bad = 0;
    sw[6] = 1'b1;
    cyc(3);
    sw[6] = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      cyc();
      if (in_port1 !== 32'h0) bad++;
    end
    ncmp++;
    if (bad != 0) begin nfail++; $display("FAIL glitch_in1: %0d cycles nonzero want 0", bad); end
    rd(BASE | 32'h88, d, v, e);
    ncmp++;
    if (d !== 32'h0) begin nfail++; $display("FAIL glitch_status: got %h want 0", d); end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    logic        v, e;
    sw[9] = 1'b1;
    cyc(LAT);
    rd(BASE | 32'h88, d, v, e);
    ncmp++;
    if (d !== 32'h0 || in_port1 !== 32'h10) begin
      nfail++; $display("FAIL collide_first: status %h in1 %h want 0 10", d, in_port1);
    end
    rd(BASE | 32'h88, d, v, e);
    ncmp++;
    if (d !== 32'h200) begin nfail++; $display("FAIL collide_kept: got %h want 200", d); end
  endtask

  task automatic test_errors;
    logic [31:0] d;
    logic        v, e;
    wr(BASE | 32'h00, 32'h1111_1111);
    wr(BASE | 32'h04, 32'h2222_2222);
    wr(BASE | 32'h08, 32'h3333_3333);
    wr(BASE | 32'h80, 32'hDEAD_BEEF);
    ncmp++;
    if (io_err !== 1'b1 || in_port0 !== 32'h1 || out_port0 !== 32'h1111_1111) begin
      nfail++; $display("FAIL err_wr_in0: err %b in0 %h out0 %h want 1 1 11111111", io_err, in_port0, out_port0);
    end
    cyc();
    ncmp++;
    if (io_err !== 1'b0) begin nfail++; $display("FAIL err_pulse: got %b want 0", io_err); end
    wr(BASE | 32'h02, 32'hBEEF_0000);
    ncmp++;
    if (io_err !== 1'b1 || out_port0 !== 32'h1111_1111 || out_port1 !== 32'h2222_2222) begin
      nfail++; $display("FAIL err_misalign: err %b out0 %h out1 %h want 1 11111111 22222222", io_err, out_port0, out_port1);
    end
    rd(BASE | 32'h40, d, v, e);
    ncmp++;
    if (d !== 32'h0 || v !== 1'b1 || e !== 1'b1) begin
      nfail++; $display("FAIL err_rd_unmapped: rdata %h rv %b err %b want 0 1 1", d, v, e);
    end
    wr(32'h0000_0004, 32'hCAFE_CAFE);
    ncmp++;
    if (io_err !== 1'b0 || out_port1 !== 32'h2222_2222) begin
      nfail++; $display("FAIL miss_wr: err %b out1 %h want 0 22222222", io_err, out_port1);
    end
    rd(32'h0000_0080, d, v, e);
    ncmp++;
    if (v !== 1'b0 || e !== 1'b0 || d !== 32'h0) begin
      nfail++; $display("FAIL miss_rd: rv %b err %b rdata %h want 0 0 0", v, e, d);
    end
  endtask

  task automatic test_random;
    logic [31:0] out_m [3];
    logic [9:0]  sw_m;
    logic [31:0] last_m;
    logic [31:0] d, a, wd, exp_d;
    logic        v, e, hit, is_wr, exp_e;
    logic [7:0]  offs [10];
    logic [7:0]  off;
    offs = '{8'h00, 8'h04, 8'h08, 8'h80, 8'h84, 8'h88, 8'h40, 8'h02, 8'h8C, 8'h07};
    sw_m = 10'($urandom_range(0, 1023));
    sw   = sw_m;
    cyc(LAT + 4);
    rd(BASE | 32'h88, d, v, e);
    for (int i = 0; i < 3; i++) begin
      out_m[i] = $urandom;
      wr(BASE | 32'(4 * i), out_m[i]);
    end
    rd(BASE, d, v, e);
    last_m = out_m[0];
    ncmp++;
    if (d !== last_m) begin nfail++; $display("FAIL rnd_init: got %h want %h", d, last_m); end
    for (int n = 0; n < 80; n++) begin
      off   = offs[$urandom_range(0, 9)];
      hit   = ($urandom_range(0, 3) != 0);
      a     = hit ? (BASE | 32'(off)) : {($urandom & 32'h7FFF_FF00) | 32'(off)};
      is_wr = $urandom_range(0, 1) == 1;
      if (is_wr) begin
        wd = $urandom;
        wr(a, wd);
        exp_e = hit && !(off == 8'h00 || off == 8'h04 || off == 8'h08);
        if (hit && !exp_e) out_m[off / 4] = wd;
        ncmp++;
        if (io_err !== exp_e || out_port0 !== out_m[0] || out_port1 !== out_m[1] || out_port2 !== out_m[2]) begin
          nfail++;
          $display("FAIL rnd_wr%0d addr %h: err %b out %h %h %h want %b %h %h %h", n, a, io_err,
                   out_port0, out_port1, out_port2, exp_e, out_m[0], out_m[1], out_m[2]);
        end
      end else begin
        rd(a, d, v, e);
        exp_d = 32'h0;
        exp_e = 1'b0;
        if (!hit) exp_d = last_m;
        else begin
          case (off)
            8'h00, 8'h04, 8'h08: exp_d = out_m[off / 4];
            8'h80: exp_d = {27'b0, sw_m[4:0]};
            8'h84: exp_d = {27'b0, sw_m[9:5]};
            8'h88: exp_d = 32'h0;
            default: exp_e = 1'b1;
          endcase
          last_m = exp_d;
        end
        ncmp++;
        if (d !== exp_d || v !== hit || e !== exp_e) begin
          nfail++;
          $display("FAIL rnd_rd%0d addr %h: rdata %h rv %b err %b want %h %b %b", n, a, d, v, e, exp_d, hit, exp_e);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    io_addr  = '0;
    io_wdata = '0;
    io_we    = 1'b0;
    io_re    = 1'b0;
    sw       = '0;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    test_reset();
    test_write_readback();
    test_debounce_accept();
    test_glitch_reject();
    test_collision();
    test_errors();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
Memory-mapped I/O controller between the CPU data-memory stage and the board switches and seven-segment output ports. It decodes CPU I/O accesses and holds the three output port registers. It also debounces the ten slide switches into two input ports and keeps a sticky change-status register. The CPU sees a single-cycle write and a one-cycle registered read.

Parameters:
DEBOUNCE_CYCLES, 50000, stable cycles required before a switch change is accepted (1 ms at 50 MHz); minimum 2
IO_BASE, 32'hFFFF_FF00, I/O window base; only bits [31:8] are compared

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
io_addr  input  32  CPU byte address
io_wdata  input  32  CPU write data
io_we  input  1  write strobe, one cycle per access
io_re  input  1  read strobe, one cycle per access
io_rdata  output  32  read data, valid while io_rvalid=1
io_rvalid  output  1  one-cycle pulse, one cycle after io_re
io_err  output  1  one-cycle pulse on an illegal access
sw  input  10  raw asynchronous slide switches
out_port0  output  32  output register, offset 0x00
out_port1  output  32  output register, offset 0x04
out_port2  output  32  output register, offset 0x08
in_port0  output  32  {27'b0, debounced sw[4:0]}
in_port1  output  32  {27'b0, debounced sw[9:5]}

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: all outputs are 0. Synchronizers, debounced values, counters and the status register are all cleared.
- Address decode: hit = (io_addr[31:8] == IO_BASE[31:8]); offset = io_addr[7:0].
- Register map:
  - 0x00/0x04/0x08: out_port0/1/2, read-write.
  - 0x80: in_port0, read-only.
  - 0x84: in_port1, read-only.
  - 0x88: status, read-clear. Bits [9:0] are per-switch debounced-change flags; upper bits read 0.
- Write path:
  - The write takes effect on the clk edge where io_we=1 and hit=1, so the new value is visible on out_portN the next cycle.
  - A write to 0x80, 0x84, 0x88, an unmapped offset, or a misaligned address (io_addr[1:0] != 0) has no effect and pulses io_err.
  - io_we with hit=0 is ignored silently.
- Read path:
  - io_re with hit=1 gives io_rvalid=1 and io_rdata=register the next cycle.
  - An unmapped or misaligned read returns io_rdata=0 with io_rvalid=1 and pulses io_err.
  - io_re with hit=0 gives no io_rvalid.
  - io_rdata holds its last value while io_rvalid=0.
- Simultaneous io_we and io_re at the same address: the read returns the pre-write value; the write still lands.
- Status register:
  - A bit sets on the cycle its debounced value changes.
  - A read of 0x88 clears the bits that were returned.
  - If a change and a read-clear occur on the same cycle, the set wins (no event lost).
- Debounce, per switch:
  - Two-flop synchronizer feeds a per-bit FSM with states STABLE and COUNTING.
  - STABLE: if sync != stable, go to COUNTING with cnt=0.
  - COUNTING, sync == stable: glitch; return to STABLE, cnt=0.
  - COUNTING, cnt == DEBOUNCE_CYCLES-1: stable <= sync, pulse change, go to STABLE.
  - COUNTING, otherwise: cnt+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps.
  - Latency from raw edge to in_port update = 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Reset asserted mid-count aborts the count. After release, a held-high switch is accepted only after a full debounce.

Decomposition:
- Shared package io_pkg: offset constants OFF_OUT0/1/2, OFF_IN0/1, OFF_STATUS; NUM_SW=10.
- One sub-module, sw_debounce: single-bit synchronizer plus FSM, parameter DEBOUNCE_CYCLES; outputs stable and change. Instantiated 10 times via generate.

Test Plan (DEBOUNCE_CYCLES=4, IO_BASE default):
- Reset: assert reset mid-run, asynchronously -> all outputs 0 immediately, without waiting for a clk edge; after release, read 0x80 -> io_rdata=0, io_rvalid=1 exactly one cycle after io_re.
- Write/readback: write 0x0000_0012 to 0xFFFF_FF04 -> out_port1=0x12 the next cycle; read 0xFFFF_FF04 -> 0x12. Read and write 0x55 to 0x04 in the same cycle -> read returns 0x12, then out_port1=0x55.
- Debounce accept: sw[0] 0->1 and held -> in_port0=1 exactly 7 cycles after the edge; status bit0=1; read 0x88 returns 0x001; a second read returns 0.
- Glitch reject: sw[6] high for 3 cycles, then low -> in_port1 stays 0; status stays 0.
- Set/clear collision: read 0x88 on the same cycle sw[9]'s debounce completes -> bit9 remains 1 on the next read.
- Errors: write to 0xFFFF_FF80, write to 0xFFFF_FF02, read 0xFFFF_FF40 -> io_err pulse each; no register changes; the read returns 0 with io_rvalid=1. Write to 0x0000_0004 -> no io_err, no effect.
